// File: rtl/vp_cart_pkg.sv
// Shared types and constants for the Videopac cartridge ROM controller.
package vp_cart_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_LOAD_LO = 2'd1,
    ST_LOAD_HI = 2'd2,
    ST_RUN     = 2'd3
  } cart_state_t;

  localparam int unsigned BANK0_MIN  = 32'h0000_1000;
  localparam int unsigned BANK1_MIN  = 32'h0000_2000;
  localparam logic [7:0]  RESET_DATA = 8'hFF;

  // A bank line only reaches the ROM once the image is large enough to need it.
  function automatic logic bank_en(input int unsigned size, input int unsigned thr);
    return size > thr;
  endfunction

endpackage

// File: rtl/vp_cart_map.sv
// Console cartridge address + BS0/BS1 to ROM byte address mapper.
module vp_cart_map
  import vp_cart_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic [11:0]       i_cpu_addr,
  input  logic              i_bs0,
  input  logic              i_bs1,
  input  logic [ADDR_W:0]   i_cart_size,
  output logic [ADDR_W-1:0] o_rom_addr
);

  logic        w_b0;
  logic        w_b1;
  logic [12:0] w_map;
  logic        w_unused_a10;

  // A10 is not decoded by the cartridge slot; A11 selects the upper 1 KiB.
  always_comb begin
    w_b0       = i_bs0 & bank_en(32'(i_cart_size), BANK0_MIN);
    w_b1       = i_bs1 & bank_en(32'(i_cart_size), BANK1_MIN);
    w_map      = {w_b1, w_b0, i_cpu_addr[11], i_cpu_addr[9:0]};
    o_rom_addr = ADDR_W'(w_map);
  end

  assign w_unused_a10 = i_cpu_addr[10];

endmodule

// File: rtl/vp_cart_ctrl.sv
// Cartridge ROM controller: HPS download into ROM, then console fetches.
// VP_WORD_LOAD_EN selects 16-bit word packing; undefined gives byte-mode load.
//
// state      | meaning
// BOOT       | no image; console held in reset, ROM idle
// LOAD_LO    | download active; low byte written on dl_wr_i
// LOAD_HI    | high byte of the current word written, dl_wait_o high
// RUN        | image resident; console runs and fetches from ROM
module vp_cart_ctrl
  import vp_cart_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              res_n_i,
  input  logic              dl_active_i,
  input  logic              dl_wr_i,
  input  logic [24:0]       dl_addr_i,
  input  logic [15:0]       dl_data_i,
  output logic              dl_wait_o,
  input  logic [11:0]       cpu_addr_i,
  input  logic              cpu_bs0_i,
  input  logic              cpu_bs1_i,
  output logic [7:0]        cpu_data_o,
  output logic              cpu_res_n_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [7:0]        rom_data_o,
  output logic              rom_we_o,
  input  logic [7:0]        rom_q_i,
  output logic [ADDR_W:0]   cart_size_o,
  output logic              load_done_o
);

  localparam logic [ADDR_W:0] LP_SIZE_FULL = {1'b1, {ADDR_W{1'b0}}};

  cart_state_t       r_state;
  logic              r_act_q;
  logic [ADDR_W:0]   r_size;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [7:0]        r_rom_data;
  logic              r_rom_we;
  logic              r_dl_wait;
  logic [7:0]        r_cpu_data;
  logic              r_cpu_res_n;
  logic              r_load_done;

  logic              w_rise;
  logic              w_fall;
  logic              w_lo_ok;
  logic              w_wr_byte;
  logic [ADDR_W:0]   w_size_nxt;
  cart_state_t       w_exit_state;
  logic [ADDR_W-1:0] w_map_addr;

  assign w_rise  = dl_active_i & ~r_act_q;
  assign w_fall  = ~dl_active_i & r_act_q;
  assign w_lo_ok = (dl_addr_i[24:ADDR_W] == '0);

`ifdef VP_WORD_LOAD_EN
  logic [25:0]       w_addr_p1;
  logic [ADDR_W-1:0] r_hi_addr;
  logic [7:0]        r_hi_data;
  logic              r_hi_ok;
  logic              r_exit_pend;

  assign w_addr_p1 = {1'b0, dl_addr_i} + 26'd1;
  assign w_wr_byte = ((r_state == ST_LOAD_LO) && dl_wr_i && w_lo_ok)
                   || ((r_state == ST_LOAD_HI) && r_hi_ok);
`else
  logic w_unused_hi;

  assign w_unused_hi = ^dl_data_i[15:8];
  assign w_wr_byte   = (r_state == ST_LOAD_LO) && dl_wr_i && w_lo_ok;
`endif

  assign w_size_nxt = !w_wr_byte                ? r_size :
                      (r_size == LP_SIZE_FULL)  ? r_size :
                      r_size + (ADDR_W+1)'(1);

  // Exit uses the size including any byte written this cycle.
  assign w_exit_state = (w_size_nxt != '0) ? ST_RUN : ST_BOOT;

  vp_cart_map #(
    .ADDR_W (ADDR_W)
  ) u_map (
    .i_cpu_addr  (cpu_addr_i),
    .i_bs0       (cpu_bs0_i),
    .i_bs1       (cpu_bs1_i),
    .i_cart_size (r_size),
    .o_rom_addr  (w_map_addr)
  );

  // r_act_q resets high so a download already active across reset is not
  // mistaken for a new one; a fresh load needs dl_active_i seen low first.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_state     <= ST_BOOT;
      r_act_q     <= 1'b1;
      r_size      <= '0;
      r_rom_addr  <= '0;
      r_rom_data  <= '0;
      r_rom_we    <= 1'b0;
      r_dl_wait   <= 1'b0;
      r_cpu_data  <= RESET_DATA;
      r_cpu_res_n <= 1'b0;
      r_load_done <= 1'b0;
`ifdef VP_WORD_LOAD_EN
      r_hi_addr   <= '0;
      r_hi_data   <= '0;
      r_hi_ok     <= 1'b0;
      r_exit_pend <= 1'b0;
`endif
    end else begin
      r_act_q   <= dl_active_i;
      r_rom_we  <= 1'b0;
      r_dl_wait <= 1'b0;
      if (w_rise) begin
        r_state     <= ST_LOAD_LO;
        r_size      <= '0;
        r_load_done <= 1'b0;
        r_cpu_res_n <= 1'b0;
`ifdef VP_WORD_LOAD_EN
        r_exit_pend <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_BOOT: begin
            r_cpu_res_n <= 1'b0;
          end
          ST_LOAD_LO: begin
            if (dl_wr_i) begin
              r_rom_addr <= dl_addr_i[ADDR_W-1:0];
              r_rom_data <= dl_data_i[7:0];
              r_rom_we   <= w_lo_ok;
              r_size     <= w_size_nxt;
            end
`ifdef VP_WORD_LOAD_EN
            if (dl_wr_i) begin
              r_dl_wait   <= 1'b1;
              r_hi_addr   <= w_addr_p1[ADDR_W-1:0];
              r_hi_data   <= dl_data_i[15:8];
              r_hi_ok     <= (w_addr_p1[25:ADDR_W] == '0);
              r_exit_pend <= w_fall;
              r_state     <= ST_LOAD_HI;
            end else if (w_fall) begin
              r_state <= w_exit_state;
            end
`else
            if (w_fall) begin
              r_state <= w_exit_state;
            end
`endif
          end
          ST_LOAD_HI: begin
`ifdef VP_WORD_LOAD_EN
            r_rom_addr  <= r_hi_addr;
            r_rom_data  <= r_hi_data;
            r_rom_we    <= r_hi_ok;
            r_size      <= w_size_nxt;
            r_exit_pend <= 1'b0;
            r_state     <= (w_fall || r_exit_pend) ? w_exit_state : ST_LOAD_LO;
`else
            r_state <= ST_BOOT;
`endif
          end
          ST_RUN: begin
            r_rom_addr  <= w_map_addr;
            r_cpu_data  <= rom_q_i;
            r_cpu_res_n <= 1'b1;
            r_load_done <= 1'b1;
          end
          default: begin
            r_state <= ST_BOOT;
          end
        endcase
      end
    end
  end

  assign dl_wait_o   = r_dl_wait;
  assign cpu_data_o  = r_cpu_data;
  assign cpu_res_n_o = r_cpu_res_n;
  assign rom_addr_o  = r_rom_addr;
  assign rom_data_o  = r_rom_data;
  assign rom_we_o    = r_rom_we;
  assign cart_size_o = r_size;
  assign load_done_o = r_load_done;

endmodule

// File: tb/tb_vp_cart_ctrl.sv
// Scoreboard bench for vp_cart_ctrl: ROM writes and fetches checked by a monitor.
module tb_vp_cart_ctrl;

  localparam int AW = 14;
`ifdef VP_WORD_LOAD_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          dl_active = 1'b0;
  logic          dl_wr = 1'b0;
  logic [24:0]   dl_addr = '0;
  logic [15:0]   dl_data = '0;
  logic          dl_wait;
  logic [11:0]   cpu_addr = '0;
  logic          bs0 = 1'b0;
  logic          bs1 = 1'b0;
  logic [7:0]    cpu_data;
  logic          cpu_res_n;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_we;
  logic [7:0]    rom_q;
  logic [AW:0]   cart_size;
  logic          load_done;

  logic [7:0]    mem [0:(1<<AW)-1];

  typedef struct {logic [13:0] addr; logic [7:0] data;} wr_t;
  typedef struct {int due; bit is_data; logic [13:0] addr; logic [7:0] data;} rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  int wait_cnt = 0;

  vp_cart_ctrl #(.ADDR_W(AW)) dut (
    .clk_i       (clk),
    .res_n_i     (res_n),
    .dl_active_i (dl_active),
    .dl_wr_i     (dl_wr),
    .dl_addr_i   (dl_addr),
    .dl_data_i   (dl_data),
    .dl_wait_o   (dl_wait),
    .cpu_addr_i  (cpu_addr),
    .cpu_bs0_i   (bs0),
    .cpu_bs1_i   (bs1),
    .cpu_data_o  (cpu_data),
    .cpu_res_n_o (cpu_res_n),
    .rom_addr_o  (rom_addr),
    .rom_data_o  (rom_data),
    .rom_we_o    (rom_we),
    .rom_q_i     (rom_q),
    .cart_size_o (cart_size),
    .load_done_o (load_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rom_we) mem[rom_addr] <= rom_data;
    rom_q <= mem[rom_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] pat(input int a);
    if (a == 0) return 8'h5A;
    if (a == 1) return 8'hA5;
    return 8'((a * 7) ^ (a >> 6));
  endfunction

  // Monitor: pops expectations when the DUT presents writes or when a fetch is due.
  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    if (res_n) begin
      if (dl_wait) wait_cnt++;
      if (rom_we) begin
        if (wr_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", rom_addr, rom_data);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(rom_addr), 32'(w.addr));
          check("wr_data", 32'(rom_data), 32'(w.data));
        end
      end
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        r = rd_q.pop_front();
        if (r.is_data) check("rd_data", 32'(cpu_data), 32'(r.data));
        else           check("rd_addr", 32'(rom_addr), 32'(r.addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int a, input logic [7:0] d);
    if (a < (1 << AW)) wr_q.push_back('{14'(a), d});
  endtask

`ifdef VP_WORD_LOAD_EN
  task automatic dl_put(input int a);
    dl_addr = 25'(a);
    dl_data = {pat(a + 1), pat(a)};
    dl_wr   = 1'b1;
    push_wr(a, pat(a));
    push_wr(a + 1, pat(a + 1));
    tick();
    dl_wr = 1'b0;
    tick();
  endtask
`else
  task automatic dl_put(input int a);
    dl_addr = 25'(a);
    dl_data = {~pat(a), pat(a)};
    dl_wr   = 1'b1;
    push_wr(a, pat(a));
    tick();
    dl_wr = 1'b0;
  endtask
`endif

  task automatic start_load();
    dl_active = 1'b1;
    tick();
    check("load_res_n", 32'(cpu_res_n), 0);
    check("load_done_clr", 32'(load_done), 0);
    check("load_size_clr", 32'(cart_size), 0);
    wait_cnt = 0;
  endtask

  task automatic finish_load(input int exp_size, input int exp_waits);
    dl_active = 1'b0;
    tick();
    check("res_n_before_run", 32'(cpu_res_n), 0);
    tick();
    check("res_n_run", 32'(cpu_res_n), 1);
    check("load_done", 32'(load_done), 1);
    check("cart_size", 32'(cart_size), 32'(exp_size));
    check("wait_pulses", 32'(wait_cnt), 32'(exp_waits));
  endtask

  task automatic rd(input logic [11:0] a, input logic b0, input logic b1,
                    input int exp_addr, input logic [7:0] exp_d);
    cpu_addr = a;
    bs0 = b0;
    bs1 = b1;
    rd_q.push_back('{cyc + 1, 1'b0, 14'(exp_addr), 8'h00});
    rd_q.push_back('{cyc + 3, 1'b1, 14'h0, exp_d});
    repeat (4) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 res_n = 1'b1;
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_rom_data", 32'(rom_data), 0);
    check("rst_rom_we", 32'(rom_we), 0);
    check("rst_dl_wait", 32'(dl_wait), 0);
    check("rst_cpu_data", 32'(cpu_data), 32'hFF);
    check("rst_cart_size", 32'(cart_size), 0);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_res_n", 32'(cpu_res_n), 0);
      check("idle_cpu_data", 32'(cpu_data), 32'hFF);
      check("idle_load_done", 32'(load_done), 0);
    end

    // 2 KiB image: bank lines masked, A10 ignored
    start_load();
    for (int a = 0; a < 'h800; a += STEP) dl_put(a);
    finish_load('h800, (STEP == 2) ? 'h400 : 0);
    rd(12'h400, 1'b1, 1'b1, 'h000, 8'h5A);
    rd(12'h001, 1'b0, 1'b0, 'h001, 8'hA5);
    rd(12'h7FF, 1'b1, 1'b0, 'h3FF, pat('h3FF));
    rd(12'hC00, 1'b0, 1'b1, 'h400, pat('h400));

    // 4 KiB image: exactly at the bank-0 threshold, still masked
    start_load();
    for (int a = 0; a < 'h1000; a += STEP) dl_put(a);
    finish_load('h1000, (STEP == 2) ? 'h800 : 0);
    rd(12'h805, 1'b1, 1'b1, 'h405, pat('h405));

    // 12 KiB image: both bank lines active
    start_load();
    for (int a = 0; a < 'h3000; a += STEP) dl_put(a);
    finish_load('h3000, (STEP == 2) ? 'h1800 : 0);
    rd(12'h805, 1'b1, 1'b1, 'h1C05, pat('h1C05));
    rd(12'h805, 1'b1, 1'b0, 'h0C05, pat('h0C05));
    rd(12'h3FF, 1'b0, 1'b1, 'h13FF, pat('h13FF));

    // Full image plus out-of-range and repeated bytes: size saturates
    start_load();
    check("cpu_data_hold", 32'(cpu_data), 32'(pat('h13FF)));
    for (int a = 0; a < 'h4000; a += STEP) dl_put(a);
    dl_put('h3FFF);
    dl_put('h4000);
    check("cpu_data_hold_load", 32'(cpu_data), 32'(pat('h13FF)));
    finish_load('h4000, (STEP == 2) ? 'h2002 : 0);
    rd(12'hBFF, 1'b1, 1'b1, 'h1FFF, pat('h1FFF));

    // Reset in the middle of a load
    dl_active = 1'b1;
    tick();
    dl_addr = 25'h10;
    dl_data = {pat('h11), pat('h10)};
    dl_wr   = 1'b1;
    push_wr('h10, pat('h10));
    tick();
    dl_wr = 1'b0;
    @(negedge clk);
    #1;
    res_n = 1'b0;
    #1;
    check("mid_rst_dl_wait", 32'(dl_wait), 0);
    check("mid_rst_rom_we", 32'(rom_we), 0);
    check("mid_rst_rom_addr", 32'(rom_addr), 0);
    check("mid_rst_res_n", 32'(cpu_res_n), 0);
    check("mid_rst_cpu_data", 32'(cpu_data), 32'hFF);
    check("mid_rst_size", 32'(cart_size), 0);
    check("mid_rst_done", 32'(load_done), 0);
    repeat (2) tick();
    res_n = 1'b1;
    repeat (3) tick();
    dl_active = 1'b0;
    repeat (20) tick();
    check("boot_after_fall_res_n", 32'(cpu_res_n), 0);
    check("boot_after_fall_done", 32'(load_done), 0);
    check("boot_after_fall_size", 32'(cart_size), 0);

    check("wr_queue_drained", 32'(wr_q.size()), 0);
    check("rd_queue_drained", 32'(rd_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
